// File: rtl/ysyx_25030077_pc_unit.sv
// ysyx_25030077_pc_unit: architectural PC register with fetch/resolve handshakes, traps, alignment check and taken counter
module ysyx_25030077_pc_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h8000_0000,
  parameter bit ALIGN_CHECK = 1'b1,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [XLEN-1:0]  io_pc,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [XLEN-1:0]  io_rs1_data,
  input  logic [XLEN-1:0]  io_rs2_data,
  input  logic [31:0]      io_instruction,
  input  logic [3:0]       io_pc_next_type,
  input  logic [XLEN-1:0]  io_mtvec,
  input  logic [XLEN-1:0]  io_mepc,
  output logic             io_exc_valid,
  output logic [XLEN-1:0]  io_exc_addr,
  output logic             io_halted,
  output logic             io_is_unknown_instruction,
  output logic [CNT_W-1:0] io_taken_count
);
  typedef enum logic [1:0] {BOOT, FETCH, EXEC, HALT} state_t;
  state_t state;
  logic [3:0] t;
  logic [31:0] inst;
  logic [XLEN-1:0] imm_j, imm_i, imm_b, target, next;
  logic is_br, slt, ult, cond, taken, unknown, stop, misalign;
  assign t = io_pc_next_type;
  assign inst = io_instruction;
  assign imm_j = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign imm_b = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  always_comb begin
    is_br = t >= 4'd5 && t <= 4'd10;
    unknown = t == 4'd3 || t >= 4'd13;
    stop = unknown || t == 4'd4;
    slt = $signed(io_rs1_data) < $signed(io_rs2_data);
    ult = io_rs1_data < io_rs2_data;
    cond = t == 4'd5 ? io_rs1_data != io_rs2_data :
           t == 4'd6 ? io_rs1_data == io_rs2_data :
           t == 4'd7 ? !slt : t == 4'd8 ? !ult : t == 4'd9 ? slt : ult;
    taken = t == 4'd1 || t == 4'd2 || t == 4'd11 || t == 4'd12 || (is_br && cond);
    target = t == 4'd1 ? io_pc + imm_j :
             t == 4'd2 ? (io_rs1_data + imm_i) & ~XLEN'(1) :
             t == 4'd11 ? io_mtvec : t == 4'd12 ? io_mepc : io_pc + imm_b;
    // only taken transfers are alignment-checked; a fault redirects to the trap vector
    misalign = ALIGN_CHECK && taken && |target[1:0];
    next = misalign ? io_mtvec : taken ? target : stop ? io_pc : io_pc + XLEN'(4);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= BOOT;
      io_pc <= RESET_VECTOR;
      io_out_valid <= 1'b0;
      io_in_ready <= 1'b0;
      io_exc_valid <= 1'b0;
      io_exc_addr <= '0;
      io_halted <= 1'b0;
      io_is_unknown_instruction <= 1'b0;
      io_taken_count <= '0;
    end else begin
      io_exc_valid <= 1'b0;
      case (state)
        BOOT: begin
          state <= FETCH;
          io_out_valid <= 1'b1;
        end
        FETCH: if (io_out_ready) begin
          state <= EXEC;
          io_out_valid <= 1'b0;
          io_in_ready <= 1'b1;
        end
        EXEC: if (io_in_valid) begin
          io_pc <= next;
          io_in_ready <= 1'b0;
          if (taken) io_taken_count <= io_taken_count + CNT_W'(1);
          if (misalign) begin
            io_exc_valid <= 1'b1;
            io_exc_addr <= target;
          end
          if (stop) begin
            state <= HALT;
            io_halted <= 1'b1;
            io_is_unknown_instruction <= unknown;
          end else begin
            state <= FETCH;
            io_out_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_25030077_pc_unit.sv
// tb_ysyx_25030077_pc_unit: randomized scoreboard bench against a behavioural next-PC model
module tb_ysyx_25030077_pc_unit;
  localparam logic [31:0] RV = 32'h8000_0000;
  logic clock = 0, reset = 1;
  logic io_out_ready = 0, io_in_valid = 0;
  logic [31:0] io_rs1_data = 0, io_rs2_data = 0, io_instruction = 0, io_mtvec = 0, io_mepc = 0;
  logic [3:0] io_pc_next_type = 0;
  logic io_out_valid, io_in_ready, io_exc_valid, io_halted, io_is_unknown_instruction;
  logic [31:0] io_pc, io_exc_addr, io_taken_count;
  logic ov2, ir2, ev2, h2, u2;
  logic [31:0] pc2, ea2;
  logic [3:0] cnt2;
  int checks = 0, errors = 0;

  typedef struct {
    logic [31:0] pc, cnt, eaddr;
    logic exc, halt, unk;
  } exp_t;
  exp_t q[$];
  logic [31:0] m_pc, m_cnt, m_eaddr;

  always #5 clock = ~clock;

  ysyx_25030077_pc_unit dut (
    .clock(clock), .reset(reset), .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_pc(io_pc), .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_rs1_data(io_rs1_data), .io_rs2_data(io_rs2_data), .io_instruction(io_instruction),
    .io_pc_next_type(io_pc_next_type), .io_mtvec(io_mtvec), .io_mepc(io_mepc),
    .io_exc_valid(io_exc_valid), .io_exc_addr(io_exc_addr), .io_halted(io_halted),
    .io_is_unknown_instruction(io_is_unknown_instruction), .io_taken_count(io_taken_count));

  ysyx_25030077_pc_unit #(.CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .io_out_valid(ov2), .io_out_ready(io_out_ready),
    .io_pc(pc2), .io_in_valid(io_in_valid), .io_in_ready(ir2),
    .io_rs1_data(io_rs1_data), .io_rs2_data(io_rs2_data), .io_instruction(io_instruction),
    .io_pc_next_type(io_pc_next_type), .io_mtvec(io_mtvec), .io_mepc(io_mepc),
    .io_exc_valid(ev2), .io_exc_addr(ea2), .io_halted(h2),
    .io_is_unknown_instruction(u2), .io_taken_count(cnt2));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Monitor: every new fetch offer or halt entry reveals one committed resolution
  logic pv = 0, ph = 0, pr = 0;
  always @(negedge clock) begin
    logic rv, rh;
    exp_t e;
    rv = io_out_valid && !pv;
    rh = io_halted && !ph;
    if (pr && !reset) chk("exc_pulse_len", {31'b0, io_exc_valid}, 32'd0);
    if (rv || rh) begin
      if (q.size() == 0) chk("unexpected_commit", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("pc", io_pc, e.pc);
        chk("count", io_taken_count, e.cnt);
        chk("count4", {28'b0, cnt2}, {28'b0, e.cnt[3:0]});
        chk("exc_valid", {31'b0, io_exc_valid}, {31'b0, e.exc});
        chk("exc_addr", io_exc_addr, e.eaddr);
        chk("halted", {31'b0, io_halted}, {31'b0, e.halt});
        chk("unknown", {31'b0, io_is_unknown_instruction}, {31'b0, e.unk});
      end
    end
    pv = io_out_valid;
    ph = io_halted;
    pr = rv || rh;
  end

  // Reference: offsets are supplied already sign-extended, so no instruction decoding here
  task automatic ref_step(input logic [3:0] t, input logic [31:0] rs1, rs2, off, mtvec, mepc, output exp_t e);
    logic tk, stop;
    logic [31:0] tgt;
    tk = 0; stop = 0; tgt = m_pc + off;
    e.exc = 0; e.unk = 0;
    case (t)
      0: ;
      1: tk = 1;
      2: begin tk = 1; tgt = (rs1 + off) & 32'hFFFF_FFFE; end
      4: stop = 1;
      5: tk = rs1 != rs2;
      6: tk = rs1 == rs2;
      7: tk = $signed(rs1) >= $signed(rs2);
      8: tk = rs1 >= rs2;
      9: tk = $signed(rs1) < $signed(rs2);
      10: tk = rs1 < rs2;
      11: begin tk = 1; tgt = mtvec; end
      12: begin tk = 1; tgt = mepc; end
      default: begin stop = 1; e.unk = 1; end
    endcase
    if (tk) m_cnt = m_cnt + 1;
    if (tk && tgt[1:0] != 0) begin e.exc = 1; m_eaddr = tgt; m_pc = mtvec; end
    else if (tk) m_pc = tgt;
    else if (!stop) m_pc = m_pc + 4;
    e.pc = m_pc; e.cnt = m_cnt; e.eaddr = m_eaddr; e.halt = stop;
  endtask

  function automatic logic [31:0] make_inst(input logic [3:0] t, input logic [31:0] off, input logic [31:0] r);
    if (t == 1) return {off[20], off[10:1], off[11], off[19:12], r[11:0]};
    if (t == 2) return {off[11:0], r[19:0]};
    if (t >= 5 && t <= 10) return {off[12], off[10:5], r[24:12], off[4:1], off[11], r[6:0]};
    return r;
  endfunction

  task automatic do_reset();
    exp_t e;
    reset = 1; io_out_ready = 0; io_in_valid = 0;
    repeat (2) @(negedge clock);
    chk("reset_state", {io_pc[31:8], 1'b0, io_out_valid, io_in_ready, io_exc_valid, io_halted,
        io_is_unknown_instruction, |io_exc_addr, |io_taken_count}, {RV[31:8], 8'h00});
    chk("reset_count4", {28'b0, cnt2}, 32'd0);
    chk("queue_drained", q.size(), 0);
    q.delete();
    m_pc = RV; m_cnt = 0; m_eaddr = 0;
    e.pc = RV; e.cnt = 0; e.eaddr = 0; e.exc = 0; e.halt = 0; e.unk = 0;
    q.push_back(e);
    reset = 0;
    #1 chk("boot_no_valid", {31'b0, io_out_valid}, 32'd0);
  endtask

  task automatic go_exec(input int hold, output bit ok);
    int n;
    logic [31:0] pc0;
    n = 0; ok = 0;
    while (!io_out_valid && n < 40) begin @(negedge clock); n++; end
    if (!io_out_valid) begin chk("fetch_timeout", 32'd1, 32'd0); return; end
    pc0 = io_pc;
    for (int i = 0; i < hold; i++) begin
      io_in_valid = 1; io_pc_next_type = 4'd4;
      @(negedge clock);
      chk("hold_stable", {io_pc, 3'b0, io_out_valid, io_in_ready}, {pc0, 3'b0, 1'b1, 1'b0});
    end
    io_in_valid = 0; io_out_ready = 1;
    @(negedge clock);
    io_out_ready = 0;
    chk("exec_ready", {31'b0, io_in_ready}, 32'd1);
    ok = io_in_ready;
  endtask

  task automatic exec_one(input logic [3:0] t, input logic [31:0] rs1, rs2, off, mtvec, mepc, input int hold);
    bit ok;
    exp_t e;
    go_exec(hold, ok);
    if (!ok) return;
    io_pc_next_type = t; io_rs1_data = rs1; io_rs2_data = rs2;
    io_instruction = make_inst(t, off, $urandom); io_mtvec = mtvec; io_mepc = mepc;
    io_in_valid = 1;
    ref_step(t, rs1, rs2, off, mtvec, mepc, e);
    q.push_back(e);
    @(negedge clock);
    io_in_valid = 0;
    io_rs1_data = $urandom; io_rs2_data = $urandom; io_instruction = $urandom;
    io_mtvec = $urandom; io_mepc = $urandom; io_pc_next_type = 4'd4;
  endtask

  task automatic wait_halted();
    repeat (20) begin
      @(negedge clock);
      chk("halt_quiet", {29'b0, io_out_valid, io_in_ready, io_halted}, 32'd1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    logic [31:0] o, rs1, rs2, off, mtv;
    logic [3:0] t;
    io_out_ready = 1;
    do_reset();
    exec_one(0, 0, 0, 0, 0, 0, 0);
    exec_one(2, RV, 0, 0, 0, 0, 0);
    exec_one(9, 32'hFFFF_FFFF, 1, 16, 0, 0, 0);
    exec_one(10, 32'hFFFF_FFFF, 1, 16, 0, 0, 0);
    exec_one(8, 32'hFFFF_FFFF, 1, 16, 0, 0, 1);
    exec_one(2, 32'h8000_0101, 0, 1, 0, 0, 0);
    exec_one(2, 32'h8000_0010, 0, 0, 0, 0, 0);
    exec_one(1, 0, 0, 32'hFFFF_FFF8, 0, 0, 0);
    exec_one(2, 32'h8000_0005, 0, 1, 32'h8000_0100, 0, 0);
    exec_one(11, 0, 0, 0, 32'h8000_0200, 0, 5);
    exec_one(12, 0, 0, 0, 0, 32'h8000_0040, 0);
    for (int k = 0; k < 300; k++) begin
      do t = 4'($urandom_range(0, 12)); while (t == 3 || t == 4);
      o = $urandom; o[0] = 0;
      if ($urandom_range(0, 2) != 0) o[1] = 0;
      rs1 = $urandom; rs2 = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
      if ($urandom_range(0, 1) == 0) rs1[1:0] = 0;
      off = t == 1 ? {{11{o[20]}}, o[20:0]} : t == 2 ? {{20{o[11]}}, o[11:0]} : {{19{o[12]}}, o[12:0]};
      mtv = $urandom;
      if ($urandom_range(0, 7) != 0) mtv[1:0] = 0;
      exec_one(t, rs1, rs2, off, mtv, $urandom, $urandom_range(0, 2));
    end
    do_reset();
    for (int k = 0; k < 16; k++) exec_one(1, 0, 0, 8, 0, 0, 0);
    chk("count4_wrap", {28'b0, cnt2}, 32'd0);
    exec_one(4, 0, 0, 0, 0, 0, 0);
    wait_halted();
    do_reset();
    exec_one(1, 0, 0, 32'h40, 0, 0, 0);
    exec_one(0, 0, 0, 0, 0, 0, 0);
    go_exec(0, ok);
    io_pc_next_type = 4'd1; io_instruction = make_inst(1, 8, 0); io_in_valid = 1;
    #2 reset = 1;
    #1 chk("async_reset", {io_pc[31:8], 5'b0, io_in_ready, |io_taken_count, io_out_valid}, {RV[31:8], 8'h00});
    do_reset();
    exec_one(0, 0, 0, 0, 0, 0, 0);
    exec_one(3, 0, 0, 0, 0, 0, 0);
    wait_halted();
    do_reset();
    repeat (3) @(negedge clock);
    chk("queue_final", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
